// File: rtl/matmul_sched.sv
// matmul_sched: descriptor FIFO + launcher for the matmul engine (optional cycle counter via MATMUL_SCHED_CYCLES_EN)
module matmul_sched #(
    parameter int DIM_BITS = 16,
    parameter int MEM_AW   = 16,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                desc_valid,
    output logic                                desc_ready,
    input  logic [3*MEM_AW+6*DIM_BITS-1:0]      desc_data,
    input  logic                                run,
    output logic [MEM_AW-1:0]                   mm_aBASE,
    output logic [MEM_AW-1:0]                   mm_bBASE,
    output logic [MEM_AW-1:0]                   mm_cBASE,
    output logic [DIM_BITS-1:0]                 mm_aROWS,
    output logic [DIM_BITS-1:0]                 mm_aCOLS,
    output logic [DIM_BITS-1:0]                 mm_bCOLS,
    output logic [DIM_BITS-1:0]                 mm_aSTRIDE,
    output logic [DIM_BITS-1:0]                 mm_bSTRIDE,
    output logic [DIM_BITS-1:0]                 mm_cSTRIDE,
    output logic                                mm_go,
    input  logic [3:0]                          mm_state,
    input  logic                                mm_ret,
    output logic                                busy,
    output logic [$clog2(DEPTH):0]              pending,
    output logic                                done,
    output logic [15:0]                         jobs_done,
    output logic [CNT_BITS-1:0]                 last_cycles
);
    localparam int DW = 3*MEM_AW + 6*DIM_BITS;
    localparam int AW = $clog2(DEPTH);
    localparam int D0 = 3*MEM_AW;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_n;
    logic full, push, pop, launch, finish;
    assign full       = count == (AW+1)'(DEPTH);
    assign desc_ready = rst_n && !full;
    assign push       = desc_valid && desc_ready;
    assign pop        = launch;
    assign head       = mem[rd_ptr];
    assign count_n    = count + (AW+1)'(push) - (AW+1)'(pop);
    assign pending    = count;
    // descriptor storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= desc_data;
    end
    // launch when a job is queued, launches are enabled and the engine sits in its wait-for-go state
    always_comb begin
        launch  = (state == IDLE) && run && (count != '0) && (mm_state == 4'd1);
        finish  = (state == RUN) && mm_ret;
        state_n = launch ? RUN : finish ? IDLE : state;
    end
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            busy  <= (state_n == RUN) || (count_n != '0);
        end
    end
    // engine configuration is captured from the FIFO head only at launch, so it holds for the whole job
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mm_aBASE   <= '0;
            mm_bBASE   <= '0;
            mm_cBASE   <= '0;
            mm_aROWS   <= '0;
            mm_aCOLS   <= '0;
            mm_bCOLS   <= '0;
            mm_aSTRIDE <= '0;
            mm_bSTRIDE <= '0;
            mm_cSTRIDE <= '0;
        end else if (launch) begin
            mm_aBASE   <= head[0        +: MEM_AW];
            mm_bBASE   <= head[MEM_AW   +: MEM_AW];
            mm_cBASE   <= head[2*MEM_AW +: MEM_AW];
            mm_aROWS   <= head[D0              +: DIM_BITS];
            mm_aCOLS   <= head[D0 + DIM_BITS   +: DIM_BITS];
            mm_bCOLS   <= head[D0 + 2*DIM_BITS +: DIM_BITS];
            mm_aSTRIDE <= head[D0 + 3*DIM_BITS +: DIM_BITS];
            mm_bSTRIDE <= head[D0 + 4*DIM_BITS +: DIM_BITS];
            mm_cSTRIDE <= head[D0 + 5*DIM_BITS +: DIM_BITS];
        end
    end
    // go pulse, completion pulse and completed-job counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mm_go     <= 1'b0;
            done      <= 1'b0;
            jobs_done <= '0;
        end else begin
            mm_go <= launch;
            done  <= finish;
            if (finish) jobs_done <= jobs_done + 1'b1;
        end
    end
`ifdef MATMUL_SCHED_CYCLES_EN
    logic [CNT_BITS-1:0] cyc;
    // per-job cycle counter: zero in the go cycle, saturating count of RUN cycles, latched on return
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc         <= '0;
            last_cycles <= '0;
        end else begin
            if (launch)                          cyc <= '0;
            else if (state == RUN && cyc != '1) cyc <= cyc + 1'b1;
            if (finish) last_cycles <= cyc;
        end
    end
`else
    assign last_cycles = '0;
`endif
endmodule

// File: tb/tb_matmul_sched.sv
// tb_matmul_sched: directed scoreboard bench for matmul_sched
module tb_matmul_sched;
    localparam int DIM_BITS = 16;
    localparam int MEM_AW   = 16;
    localparam int DEPTH    = 4;
    localparam int CNT_BITS = 32;
    localparam int DW       = 3*MEM_AW + 6*DIM_BITS;
    logic clk = 1'b0;
    logic rst_n, desc_valid, desc_ready, run, mm_go, mm_ret, busy, done;
    logic [DW-1:0] desc_data;
    logic [MEM_AW-1:0] mm_aBASE, mm_bBASE, mm_cBASE;
    logic [DIM_BITS-1:0] mm_aROWS, mm_aCOLS, mm_bCOLS, mm_aSTRIDE, mm_bSTRIDE, mm_cSTRIDE;
    logic [3:0] mm_state;
    logic [2:0] pending;
    logic [15:0] jobs_done;
    logic [CNT_BITS-1:0] last_cycles;
    logic [DW-1:0] sb[$];
    int checks = 0;
    int errors = 0;
    int jobs_exp = 0;
    int n;
    matmul_sched #(.DIM_BITS(DIM_BITS), .MEM_AW(MEM_AW), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_data(desc_data), .run(run),
        .mm_aBASE(mm_aBASE), .mm_bBASE(mm_bBASE), .mm_cBASE(mm_cBASE),
        .mm_aROWS(mm_aROWS), .mm_aCOLS(mm_aCOLS), .mm_bCOLS(mm_bCOLS),
        .mm_aSTRIDE(mm_aSTRIDE), .mm_bSTRIDE(mm_bSTRIDE), .mm_cSTRIDE(mm_cSTRIDE),
        .mm_go(mm_go), .mm_state(mm_state), .mm_ret(mm_ret), .busy(busy),
        .pending(pending), .done(done), .jobs_done(jobs_done), .last_cycles(last_cycles)
    );
    always #5 clk = ~clk;
    wire [DW-1:0] cfg = {mm_cSTRIDE, mm_bSTRIDE, mm_aSTRIDE, mm_bCOLS, mm_aCOLS, mm_aROWS,
                         mm_cBASE, mm_bBASE, mm_aBASE};
    function automatic logic [DW-1:0] mk(input int s);
        mk = {16'(16'h60 + s), 16'(16'h50 + s), 16'(16'h40 + s),
              16'(2 + 3*s), 16'(2 + 2*s), 16'(2 + s),
              16'(16'h3000 + s), 16'(16'h2000 + s), 16'(16'h1000 + s)};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push_desc(input int s);
        desc_valid = 1'b1;
        desc_data  = mk(s);
        sb.push_back(mk(s));
        tick();
        desc_valid = 1'b0;
    endtask
    task automatic wait_go(output int cnt);
        cnt = 0;
        while (mm_go !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("go_seen", mm_go, 1);
    endtask
    task automatic expect_no_go(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            tick();
            chk("no_go", mm_go, 0);
        end
    endtask
    // called in the go cycle; plays the engine through a job of lat cycles
    task automatic do_job(input int lat, input bit drop_run);
        logic [DW-1:0] exp_d;
        if (sb.size() == 0) begin
            exp_d = '0;
            chk("sb_empty", 1, 0);
        end else exp_d = sb.pop_front();
        chk("cfg", cfg, exp_d);
        mm_state = 4'd2;
        tick();
        desc_valid = 1'b0;
        if (drop_run) run = 1'b0;
        chk("go_clear", mm_go, 0);
        for (int i = 1; i < lat; i++) tick();
        chk("cfg_hold", cfg, exp_d);
        mm_ret = 1'b1;
        tick();
        mm_ret   = 1'b0;
        mm_state = 4'd0;
        jobs_exp++;
        chk("done", done, 1);
        chk("jobs_done", jobs_done, jobs_exp);
`ifdef MATMUL_SCHED_CYCLES_EN
        chk("last_cycles", last_cycles, lat);
`else
        chk("last_cycles", last_cycles, 0);
`endif
        tick();
        mm_state = 4'd1;
        chk("done_pulse", done, 0);
        chk("go_gap", mm_go, 0);
    endtask
    initial begin
        rst_n = 1'b0; desc_valid = 1'b0; desc_data = '0; run = 1'b0; mm_state = 4'd1; mm_ret = 1'b0;
        tick();
        tick();
        chk("rst_ready", desc_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_go", mm_go, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_jobs", jobs_done, 0);
        chk("rst_cycles", last_cycles, 0);
        chk("rst_cfg", cfg, 0);
        chk("ready", desc_ready, 1);
        // single job with launch latency
        run = 1'b1;
        push_desc(0);
        chk("pend1", pending, 1);
        chk("go_early", mm_go, 0);
        wait_go(n);
        chk("latency", n, 1);
        chk("busy_run", busy, 1);
        do_job(20, 1'b0);
        chk("busy_after", busy, 0);
        // fill the FIFO with launches held off
        run = 1'b0;
        for (int i = 1; i <= 4; i++) push_desc(i);
        desc_valid = 1'b1;
        desc_data  = mk(5);
        #0;
        chk("full_ready", desc_ready, 0);
        chk("full_pending", pending, 4);
        chk("full_busy", busy, 1);
        tick();
        tick();
        chk("full_hold", pending, 4);
        run = 1'b1;
        tick();
        chk("fill_go", mm_go, 1);
        chk("fill_pend3", pending, 3);
        chk("no_bypass_ready", desc_ready, 1);
        sb.push_back(mk(5));
        do_job(4, 1'b0);
        chk("fifth_accepted", pending, 4);
        for (int j = 0; j < 4; j++) begin
            wait_go(n);
            do_job(3, 1'b0);
        end
        chk("fill_drained", pending, 0);
        chk("fill_idle", busy, 0);
        // run pause mid-job
        run = 1'b0;
        for (int i = 10; i < 14; i++) push_desc(i);
        run = 1'b1;
        wait_go(n);
        chk("pause_pend", pending, 3);
        do_job(5, 1'b1);
        expect_no_go(8);
        chk("pause_hold", pending, 3);
        run = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wait_go(n);
            do_job(3, 1'b0);
        end
        // engine not ready
        mm_state = 4'd0;
        push_desc(20);
        expect_no_go(6);
        chk("notready_pend", pending, 1);
        mm_state = 4'd1;
        tick();
        chk("ready_go", mm_go, 1);
        do_job(5, 1'b0);
        // spurious return in IDLE
        mm_ret = 1'b1;
        tick();
        mm_ret = 1'b0;
        chk("spur_done", done, 0);
        chk("spur_jobs", jobs_done, jobs_exp);
        tick();
        chk("spur_done2", done, 0);
        // reset in the middle of a job
        push_desc(30);
        push_desc(31);
        wait_go(n);
        void'(sb.pop_front());
        mm_state = 4'd2;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_pending", pending, 0);
        chk("mrst_done", done, 0);
        chk("mrst_jobs", jobs_done, 0);
        chk("mrst_go", mm_go, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", desc_ready, 0);
        chk("mrst_cfg", cfg, 0);
        rst_n = 1'b1;
        mm_state = 4'd1;
        sb.delete();
        jobs_exp = 0;
        expect_no_go(4);
        chk("mrst_nodone", done, 0);
        chk("mrst_empty", pending, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
